// File: rtl/jpeg_frame_packer.sv
// Wraps the entropy-coded byte stream of each frame in SOI/EOI markers, buffers it
// in a byte FIFO and presents it on a stallable valid/ready byte interface.
module jpeg_frame_packer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start_i,
    input  logic        data_valid_i,
    input  logic [7:0]  data_i,
    input  logic        frame_ready_i,
    input  logic        out_ready_i,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_done,
    output logic [31:0] frame_bytes,
    output logic        ovf_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, SOI_FF, SOI_D8, BODY, EOI_FF, EOI_D9, DONE
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          eof_pending;
    logic [31:0]   byte_cnt;

    logic          can_load, pop, push, load, load_last, start;
    logic [7:0]    load_data;

    assign can_load = !out_valid || out_ready_i;
    // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign push     = data_valid_i && ((count != FULL) || pop);
    assign start    = (state == IDLE) && frame_start_i;

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        load_last = 1'b0;
        case (state)
            IDLE:   if (frame_start_i) state_nx = SOI_FF;
            SOI_FF: if (can_load) begin
                load = 1'b1; load_data = 8'hFF; state_nx = SOI_D8;
            end
            SOI_D8: if (can_load) begin
                load = 1'b1; load_data = 8'hD8; state_nx = BODY;
            end
            BODY: if (can_load) begin
                if (count != '0) begin
                    pop = 1'b1; load = 1'b1; load_data = mem[rd_ptr];
                end else if (eof_pending) begin
                    state_nx = EOI_FF;
                end
            end
            EOI_FF: if (can_load) begin
                load = 1'b1; load_data = 8'hFF; state_nx = EOI_D9;
            end
            EOI_D9: begin
                // First load D9, then stay until the downstream side takes it.
                if (out_valid && out_last) begin
                    if (out_ready_i) state_nx = DONE;
                end else if (can_load) begin
                    load = 1'b1; load_data = 8'hD9; load_last = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else if (can_load) begin
            out_valid <= load;
            out_last  <= load & load_last;
            if (load) out_data <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eof_pending <= 1'b0;
            byte_cnt    <= '0;
            ovf_err     <= 1'b0;
            frame_bytes <= '0;
        end else begin
            if (start)                                  eof_pending <= 1'b0;
            else if (state != IDLE && frame_ready_i)    eof_pending <= 1'b1;

            if (start)                                  byte_cnt <= '0;
            else if (out_valid && out_ready_i)          byte_cnt <= byte_cnt + 1'b1;

            // A drop in the same cycle as frame start still counts against the new frame.
            if (data_valid_i && !push)                  ovf_err <= 1'b1;
            else if (start)                             ovf_err <= 1'b0;

            if (state == DONE)                          frame_bytes <= byte_cnt;
        end
    end

    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_jpeg_frame_packer.sv
// Scoreboard bench: stimulus queues the expected marker-wrapped byte stream, a
// negedge monitor checks every accepted output byte and output stability under stall.
module tb_jpeg_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        frame_ready_i = 1'b0;
    logic        out_ready_i = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        frame_done;
    logic [31:0] frame_bytes;
    logic        ovf_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;
    logic [8:0] exp_q[$];   // {last, data}

    jpeg_frame_packer #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start_i),
        .data_valid_i(data_valid_i), .data_i(data_i), .frame_ready_i(frame_ready_i),
        .out_ready_i(out_ready_i), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done), .frame_bytes(frame_bytes),
        .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    always @(posedge clk) if (rand_mode) begin
        #1;
        out_ready_i = 1'($urandom_range(0, 1));
    end

    // Monitor
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte got %0h expected none", out_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_byte", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
            prev_stall = out_valid && !out_ready_i;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_frame();
        frame_start_i = 1'b1;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'hD8});
        step();
        frame_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        data_valid_i = 1'b1;
        data_i = b;
        if (keep) exp_q.push_back({1'b0, b});
        step();
        data_valid_i = 1'b0;
    endtask

    task automatic end_frame();
        frame_ready_i = 1'b1;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'hD9});
        step();
        frame_ready_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_bytes, input bit exp_ovf);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        chk("frame_bytes", frame_bytes, 32'(exp_bytes));
        chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        rand_mode = 1'b0;
        #1 out_ready_i = 1'b1;
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bytes"}, frame_bytes, 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_outputs("reset");
        step(); step();
        rst = 1'b0;
        step();

        // Basic frame
        start_frame();
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        end_frame();
        wait_done(7, 1'b0);

        // Empty frame: frame_ready lands while the FSM is in SOI_FF
        frame_start_i = 1'b1;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'hD8});
        step();
        frame_start_i = 1'b0;
        end_frame();
        wait_done(4, 1'b0);

        // Backpressure: 40 sequential bytes, random ready
        rand_mode = 1'b1;
        start_frame();
        for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b1);
        end_frame();
        wait_done(44, 1'b0);

        // Random frames: random length, gaps and ready
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(0, 30);
            rand_mode = 1'b1;
            start_frame();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) step();
                send_byte(8'($urandom), 1'b1);
            end
            end_frame();
            wait_done(n + 4, 1'b0);
        end

        // Overflow: nothing drains, only the first 64 bytes survive
        out_ready_i = 1'b0;
        start_frame();
        for (int i = 0; i < 70; i++) send_byte(8'(8'h40 + i), i < 64);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        end_frame();
        out_ready_i = 1'b1;
        wait_done(68, 1'b1);
        chk("ovf_sticky_idle", 32'(ovf_err), 32'd1);

        // Full FIFO with simultaneous read and write
        start_frame();
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        repeat (5) step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 65; i++) send_byte(8'(i + 1), 1'b1);
        out_ready_i = 1'b1;
        send_byte(8'hEE, 1'b1);
        out_ready_i = 1'b0;
        step();
        chk("full_rw_no_ovf", 32'(ovf_err), 32'd0);
        end_frame();
        out_ready_i = 1'b1;
        wait_done(70, 1'b0);

        // Reset mid-body
        start_frame();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i), 1'b1);
        repeat (4) step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i), 1'b0);
        end_frame();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        step(); step();
        rst = 1'b0;
        out_ready_i = 1'b1;
        repeat (6) step();
        chk("post_reset_quiet", 32'(out_valid), 32'd0);
        chk("post_reset_queue", 32'(exp_q.size()), 32'd0);
        start_frame();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        end_frame();
        wait_done(7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
